vend_dispenser: RTL and testbench



---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_dispenser_seg7_decoder.sv | 19 +
 rtl/vend_dispenser.sv | 167 ++++++++++++++++
 tb/tb_vend_dispenser.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispenser output stage:
// FSM states, product/pending encoding and 7-segment patterns.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    COFFEE = 2'd1,
    SPRITE = 2'd2
  } prod_e;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;

endpackage

// File: rtl/vend_dispenser_seg7_decoder.sv
// Combinational decode of the 2-bit credit code into a 7-segment pattern.
// The caller registers the result.
module seg7_decoder
  import vend_pkg::*;
(
  input  logic [1:0] i_code,
  output logic [6:0] o_pattern
);

  always_comb begin
    case (i_code)
      2'd0:    o_pattern = SEG_0;
      2'd1:    o_pattern = SEG_1;
      2'd2:    o_pattern = SEG_2;
      default: o_pattern = SEG_3;
    endcase
  end

endmodule

// File: rtl/vend_dispenser.sv
// Dispenser output stage: turns controller dispense strobes into timed motor
// pulses with a one-deep pending slot, tracks stock, and drives the display.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned STOCK_INIT   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_coffee,
  input  logic               i_sprite,
  input  logic [1:0]         i_seg,
  input  logic               i_refill,
  output logic               o_motor_coffee,
  output logic               o_motor_sprite,
  output logic               o_busy,
  output logic               o_reject,
  output logic               o_empty_coffee,
  output logic               o_empty_sprite,
  output logic [STOCK_W-1:0] o_stock_coffee,
  output logic [STOCK_W-1:0] o_stock_sprite,
  output logic [6:0]         o_fnd
);

  localparam int unsigned CNT_MAX = (MOTOR_CYCLES > GAP_CYCLES) ? MOTOR_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   MOTOR_LOAD = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);

  state_e             state_q, state_d;
  prod_e              pend_q, pend_d;
  prod_e              sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STOCK_W-1:0] stock_c_q, stock_c_d;
  logic [STOCK_W-1:0] stock_s_q, stock_s_d;
  logic               reject_q, reject_d;
  logic               prev_c_q, prev_s_q;
  logic [6:0]         fnd_q, fnd_d;

  logic  req_c, req_s;
  logic  launch_pt, refill_en, blocked;
  prod_e launch, slot;

  seg7_decoder u_seg7 (
    .i_code    (i_seg),
    .o_pattern (fnd_d)
  );

  assign req_c     = i_coffee & ~prev_c_q;
  assign req_s     = i_sprite & ~prev_s_q;
  assign launch_pt = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0));
  assign refill_en = (state_q == IDLE) && (pend_q == NONE) && i_refill;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    sel_d     = sel_q;
    stock_c_d = stock_c_q;
    stock_s_d = stock_s_q;
    reject_d  = 1'b0;
    launch    = NONE;
    slot      = pend_q;
    blocked   = 1'b0;

    if (refill_en) begin
      stock_c_d = STOCK_FULL;
      stock_s_d = STOCK_FULL;
    end

    // A pending request is re-checked against stock when it is launched;
    // if it sold out meanwhile it is dropped and the machine falls to IDLE.
    if (launch_pt && (pend_q != NONE)) begin
      if (((pend_q == COFFEE) && (stock_c_q != '0)) ||
          ((pend_q == SPRITE) && (stock_s_q != '0))) begin
        launch = pend_q;
      end else begin
        reject_d = 1'b1;
        blocked  = 1'b1;
      end
      slot = NONE;
    end

    // Coffee is evaluated first so it wins a simultaneous edge.
    if (req_c) begin
      if (stock_c_d == '0)                              reject_d = 1'b1;
      else if (launch_pt && (launch == NONE) && !blocked) launch   = COFFEE;
      else if (slot == NONE)                            slot     = COFFEE;
      else                                              reject_d = 1'b1;
    end
    if (req_s) begin
      if (stock_s_d == '0)                              reject_d = 1'b1;
      else if (launch_pt && (launch == NONE) && !blocked) launch   = SPRITE;
      else if (slot == NONE)                            slot     = SPRITE;
      else                                              reject_d = 1'b1;
    end
    pend_d = slot;

    if (launch != NONE) begin
      state_d = RUN;
      cnt_d   = MOTOR_LOAD;
      sel_d   = launch;
      if ((launch == COFFEE) && (stock_c_d != '0)) stock_c_d = stock_c_d - 1'b1;
      if ((launch == SPRITE) && (stock_s_d != '0)) stock_s_d = stock_s_d - 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= NONE;
      sel_q     <= NONE;
      stock_c_q <= STOCK_FULL;
      stock_s_q <= STOCK_FULL;
      reject_q  <= 1'b0;
      prev_c_q  <= 1'b0;
      prev_s_q  <= 1'b0;
      fnd_q     <= SEG_0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      stock_c_q <= stock_c_d;
      stock_s_q <= stock_s_d;
      reject_q  <= reject_d;
      prev_c_q  <= i_coffee;
      prev_s_q  <= i_sprite;
      fnd_q     <= fnd_d;
    end
  end

  // Motors decode straight from reset flops, so reset drops them without a clock.
  assign o_motor_coffee = (state_q == RUN) && (sel_q == COFFEE);
  assign o_motor_sprite = (state_q == RUN) && (sel_q == SPRITE);
  assign o_busy         = (state_q != IDLE) || (pend_q != NONE);
  assign o_reject       = reject_q;
  assign o_empty_coffee = (stock_c_q == '0);
  assign o_empty_sprite = (stock_s_q == '0);
  assign o_stock_coffee = stock_c_q;
  assign o_stock_sprite = stock_s_q;
  assign o_fnd          = fnd_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench for vend_dispenser: a cycle-numbered reference model
// queues expected status and events; a negedge monitor pops and compares.
module tb_vend_dispenser;

  localparam int M  = 8;
  localparam int G  = 2;
  localparam int SW = 4;
  localparam int SI = 15;

  localparam int EV_COFFEE = 0;
  localparam int EV_SPRITE = 1;
  localparam int EV_REJECT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_coffee, i_sprite, i_refill;
  logic [1:0]    i_seg;
  logic          o_motor_coffee, o_motor_sprite, o_busy, o_reject;
  logic          o_empty_coffee, o_empty_sprite;
  logic [SW-1:0] o_stock_coffee, o_stock_sprite;
  logic [6:0]    o_fnd;

  always #5 clk = ~clk;

  vend_dispenser #(
    .MOTOR_CYCLES (M),
    .GAP_CYCLES   (G),
    .STOCK_W      (SW),
    .STOCK_INIT   (SI)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_coffee       (i_coffee),
    .i_sprite       (i_sprite),
    .i_seg          (i_seg),
    .i_refill       (i_refill),
    .o_motor_coffee (o_motor_coffee),
    .o_motor_sprite (o_motor_sprite),
    .o_busy         (o_busy),
    .o_reject       (o_reject),
    .o_empty_coffee (o_empty_coffee),
    .o_empty_sprite (o_empty_sprite),
    .o_stock_coffee (o_stock_coffee),
    .o_stock_sprite (o_stock_sprite),
    .o_fnd          (o_fnd)
  );

  typedef struct {
    int         stock_c;
    int         stock_s;
    bit         mc;
    bit         ms;
    bit         busy;
    logic [6:0] fnd;
  } status_t;

  typedef struct {
    int kind;
    int cyc;
  } event_t;

  status_t stq[$];
  event_t  evq[$];
  int      checks = 0;
  int      errors = 0;

  logic [6:0] seg_tbl [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};

  // Reference model: cycle k's inputs decide what cycle k+1 shows.
  int m_k        = 0;
  int m_busy_end = -1;
  int m_run_start = -100;
  int m_run_prod = -1;
  int m_pend     = -1;
  int m_stock [2] = '{SI, SI};
  bit m_prev [2]  = '{1'b0, 1'b0};

  bit mon_en  = 1'b0;
  int mon_cyc = 1;
  bit prev_mc = 1'b0;
  bit prev_ms = 1'b0;
  status_t mon_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit c, input bit s, input int seg, input bit rf);
    int      k;
    bit      idle, lp, rej, blocked;
    int      slot, launch;
    bit      rq [2];
    status_t st;
    k       = m_k;
    idle    = (k > m_busy_end);
    lp      = (k >= m_busy_end);
    slot    = m_pend;
    launch  = -1;
    rej     = 1'b0;
    blocked = 1'b0;
    rq[0]   = c && !m_prev[0];
    rq[1]   = s && !m_prev[1];
    if (idle && (m_pend < 0) && rf) m_stock = '{SI, SI};
    if (lp && (slot >= 0)) begin
      if (m_stock[slot] > 0) launch = slot;
      else begin rej = 1'b1; blocked = 1'b1; end
      slot = -1;
    end
    for (int p = 0; p < 2; p++) begin
      if (rq[p]) begin
        if (m_stock[p] == 0)                        rej    = 1'b1;
        else if (lp && (launch < 0) && !blocked)    launch = p;
        else if (slot < 0)                          slot   = p;
        else                                        rej    = 1'b1;
      end
    end
    if (launch >= 0) begin
      m_stock[launch]--;
      m_run_prod  = launch;
      m_run_start = k + 1;
      m_busy_end  = k + M + G;
      evq.push_back('{launch, k + 1});
    end
    if (rej) evq.push_back('{EV_REJECT, k + 1});
    m_pend  = slot;
    m_prev  = '{c, s};
    st.stock_c = m_stock[0];
    st.stock_s = m_stock[1];
    st.mc   = (m_run_prod == 0) && (k + 1 >= m_run_start) && (k + 1 < m_run_start + M);
    st.ms   = (m_run_prod == 1) && (k + 1 >= m_run_start) && (k + 1 < m_run_start + M);
    st.busy = (k + 1 <= m_busy_end) || (m_pend >= 0);
    st.fnd  = seg_tbl[seg];
    stq.push_back(st);
    m_k++;
  endtask

  // Drive one cycle's inputs just after the monitor has sampled.
  task automatic tick(input bit c, input bit s, input int seg, input bit rf);
    @(negedge clk);
    #1;
    i_coffee = c;
    i_sprite = s;
    i_seg    = 2'(seg);
    i_refill = rf;
    model_step(c, s, seg, rf);
    mon_en = 1'b1;
  endtask

  task automatic expect_event(input int kind);
    event_t e;
    if (evq.size() == 0) begin
      check("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = evq.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_cycle", 32'(mon_cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stq.size() == 0) begin
        check("status_underflow", 32'(stq.size()), 32'd1);
      end else begin
        mon_st = stq.pop_front();
        check("stock_coffee", 32'(o_stock_coffee), 32'(mon_st.stock_c));
        check("stock_sprite", 32'(o_stock_sprite), 32'(mon_st.stock_s));
        check("empty_coffee", 32'(o_empty_coffee), 32'(mon_st.stock_c == 0));
        check("empty_sprite", 32'(o_empty_sprite), 32'(mon_st.stock_s == 0));
        check("motor_coffee", 32'(o_motor_coffee), 32'(mon_st.mc));
        check("motor_sprite", 32'(o_motor_sprite), 32'(mon_st.ms));
        check("busy", 32'(o_busy), 32'(mon_st.busy));
        check("fnd", 32'(o_fnd), 32'(mon_st.fnd));
      end
      check("motor_exclusive", 32'(o_motor_coffee & o_motor_sprite), 32'd0);
      if (o_motor_coffee && !prev_mc) expect_event(EV_COFFEE);
      if (o_motor_sprite && !prev_ms) expect_event(EV_SPRITE);
      if (o_reject)                   expect_event(EV_REJECT);
      prev_mc = o_motor_coffee;
      prev_ms = o_motor_sprite;
      mon_cyc++;
    end
  end

  initial begin
    rst_n    = 1'b0;
    i_coffee = 1'b0;
    i_sprite = 1'b0;
    i_seg    = 2'd0;
    i_refill = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_motor_coffee", 32'(o_motor_coffee), 32'd0);
    check("rst_motor_sprite", 32'(o_motor_sprite), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_reject", 32'(o_reject), 32'd0);
    check("rst_stock_coffee", 32'(o_stock_coffee), 32'(SI));
    check("rst_stock_sprite", 32'(o_stock_sprite), 32'(SI));
    check("rst_empty", 32'({o_empty_coffee, o_empty_sprite}), 32'd0);
    check("rst_fnd", 32'(o_fnd), 32'h3F);
    #1 rst_n = 1'b1;
    tick(0, 0, 0, 0);

    // Single coffee vend: motor t+1..t+8, idle again at t+11.
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      tick(0, 0, 0, 0);
      if (i == 1) check("single_motor_on", 32'(o_motor_coffee), 32'd1);
      if (i == 1) check("single_stock", 32'(o_stock_coffee), 32'(SI - 1));
      if (i == 8) check("single_motor_last", 32'(o_motor_coffee), 32'd1);
      if (i == 9) check("single_motor_off", 32'(o_motor_coffee), 32'd0);
      if (i == 10) check("single_busy_gap", 32'(o_busy), 32'd1);
      if (i == 11) check("single_busy_end", 32'(o_busy), 32'd0);
    end
    repeat (3) tick(0, 0, 0, 0);

    // Back-to-back: sprite at t, coffee at t+3 waits in the pending slot.
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 22; i++) begin
      tick((i == 3), 0, 0, 0);
      if (i == 8)  check("b2b_sprite_last", 32'(o_motor_sprite), 32'd1);
      if (i == 9)  check("b2b_gap", 32'({o_motor_coffee, o_motor_sprite}), 32'd0);
      if (i == 10) check("b2b_gap2", 32'({o_motor_coffee, o_motor_sprite}), 32'd0);
      if (i == 11) check("b2b_coffee_first", 32'(o_motor_coffee), 32'd1);
      if (i == 18) check("b2b_coffee_last", 32'(o_motor_coffee), 32'd1);
      if (i == 19) check("b2b_coffee_off", 32'(o_motor_coffee), 32'd0);
    end

    // Overflow: third request while the slot is full is rejected at t+5.
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      tick((i == 4), (i == 2), 0, 0);
      if (i == 5) check("overflow_reject", 32'(o_reject), 32'd1);
    end

    // Simultaneous edges: coffee first, sprite after the gap.
    tick(1, 1, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      tick(0, 0, 0, 0);
      if (i == 1)  check("simul_coffee", 32'({o_motor_coffee, o_motor_sprite}), 32'b10);
      if (i == 11) check("simul_sprite", 32'({o_motor_coffee, o_motor_sprite}), 32'b01);
    end

    // Display sweep: each code appears on o_fnd one cycle later.
    for (int v = 0; v < 4; v++) begin
      tick(0, 0, v, 0);
      tick(0, 0, v, 0);
      check("fnd_sweep", 32'(o_fnd), 32'(seg_tbl[v]));
    end

    // Random traffic; refill withheld at first so both products sell out.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 3)), (i >= 1500) && ($urandom_range(0, 99) < 4));
    end
    repeat (30) tick(0, 0, 0, 0);
    check("events_drained", 32'(evq.size()), 32'd0);

    // Refill, start a coffee vend, then reset mid-RUN between clock edges.
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    check("pre_reset_motor", 32'(o_motor_coffee), 32'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_motor_off", 32'({o_motor_coffee, o_motor_sprite}), 32'd0);
    check("async_busy", 32'(o_busy), 32'd0);
    check("async_stock_coffee", 32'(o_stock_coffee), 32'(SI));
    check("async_stock_sprite", 32'(o_stock_sprite), 32'(SI));
    stq.delete();
    evq.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
